// File: rtl/position_tracker_quad_if.sv
// Stream bundle for the quadrature position tracker: sample stream in, position stream out.
// The slave modport is the tracker's view and the master modport is the environment's view.
interface position_tracker_quad_if #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int POSITION_WIDTH   = 32
);
  logic                        S_AXIS_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
  logic                        S_AXIS_tready;
  logic                        M_AXIS_tvalid;
  logic [POSITION_WIDTH-1:0]   M_AXIS_tdata;
  logic                        M_AXIS_tready;

  modport slave (
    input  S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata
  );

  modport master (
    output S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
    input  S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata
  );
endinterface

// File: rtl/position_tracker_quad.sv
// Quadrature decoder: per-channel hysteresis slicers on signed A/B samples feed an x1/x4
// position counter with a saturating illegal-transition counter and a latest-wins output.
module position_tracker_quad #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int POSITION_WIDTH   = 32,
  parameter int ERR_WIDTH        = 16
) (
  input  logic                                 SYS_aclk,
  input  logic                                 SYS_aresetn,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
  input  logic                                 FC_mode,
  input  logic                                 FC_clear,
  position_tracker_quad_if.slave               axis,
  output logic [ERR_WIDTH-1:0]                 ST_error_count
);
  localparam int HW = AXIS_TDATA_WIDTH / 2;
  localparam logic signed [POSITION_WIDTH-1:0] POS_ONE = 1;
  localparam logic [ERR_WIDTH-1:0]             ERR_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } ch_state_t;

  ch_state_t                   a_state_q, a_state_d;
  ch_state_t                   b_state_q, b_state_d;
  logic signed [POSITION_WIDTH-1:0] pos_q, pos_d;
  logic [ERR_WIDTH-1:0]        err_q, err_d;
  logic                        tvalid_q, tvalid_d;

  logic signed [HW-1:0]        a_smp, b_smp;
  logic                        accept;
  logic                        thr_ok;
  logic                        inc, dec, illegal;

  function automatic ch_state_t ch_next(input ch_state_t cur, input logic signed [HW-1:0] x,
                                        input logic signed [HW-1:0] lo,
                                        input logic signed [HW-1:0] up);
    ch_state_t nxt;
    nxt = cur;
    case (cur)
      ST_IDLE: begin
        if (x < lo)      nxt = ST_LOW;
        else if (x > up) nxt = ST_HIGH;
      end
      ST_LOW:  if (x > up) nxt = ST_HIGH;
      ST_HIGH: if (x < lo) nxt = ST_LOW;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_ONE;
  endfunction

  assign a_smp  = $signed(axis.S_AXIS_tdata[HW-1:0]);
  assign b_smp  = $signed(axis.S_AXIS_tdata[AXIS_TDATA_WIDTH-1:HW]);
  assign accept = axis.S_AXIS_tvalid;
  // An inverted threshold window freezes both slicers rather than letting them chatter.
  assign thr_ok = (FC_lower_threshold <= FC_upper_threshold);

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      a_state_q <= ST_IDLE;
      b_state_q <= ST_IDLE;
      pos_q     <= '0;
      err_q     <= '0;
      tvalid_q  <= 1'b0;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
      tvalid_q  <= tvalid_d;
    end
  end

  always_comb begin
    a_state_d = a_state_q;
    b_state_d = b_state_q;
    if (accept && thr_ok) begin
      a_state_d = ch_next(a_state_q, a_smp, FC_lower_threshold, FC_upper_threshold);
      b_state_d = ch_next(b_state_q, b_smp, FC_lower_threshold, FC_upper_threshold);
    end
  end

  always_comb begin
    inc     = 1'b0;
    dec     = 1'b0;
    illegal = 1'b0;
    // Events are judged on pre-update states, so a channel leaving IDLE never counts.
    if (accept && (a_state_q != ST_IDLE) && (b_state_q != ST_IDLE)) begin
      if (!FC_mode) begin
        if ((a_state_q == ST_HIGH) && (a_state_d == ST_LOW)) begin
          inc = (b_state_q == ST_HIGH);
          dec = (b_state_q == ST_LOW);
        end
      end else begin
        case ({a_state_q == ST_HIGH, b_state_q == ST_HIGH,
               a_state_d == ST_HIGH, b_state_d == ST_HIGH})
          4'b0010, 4'b1011, 4'b1101, 4'b0100: inc     = 1'b1;
          4'b1000, 4'b1110, 4'b0111, 4'b0001: dec     = 1'b1;
          4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal = 1'b1;
          default: ;
        endcase
      end
    end

    pos_d = pos_q;
    err_d = err_q;
    if (FC_clear) begin
      pos_d = '0;
      err_d = '0;
    end else begin
      if (inc)      pos_d = pos_q + POS_ONE;
      else if (dec) pos_d = pos_q - POS_ONE;
      if (illegal)  err_d = sat_inc(err_q);
    end

    // Latest position wins: a fresh change keeps valid up even if the old one was never taken.
    if (pos_d != pos_q)           tvalid_d = 1'b1;
    else if (axis.M_AXIS_tready)  tvalid_d = 1'b0;
    else                          tvalid_d = tvalid_q;
  end

  assign axis.S_AXIS_tready = 1'b1;
  assign axis.M_AXIS_tvalid = tvalid_q;
  assign axis.M_AXIS_tdata  = pos_q;
  assign ST_error_count     = err_q;
endmodule

// File: tb/tb_position_tracker_quad.sv
// Randomised and directed checks of position_tracker_quad against a behavioural model;
// a 32-bit/16-bit-error instance and an 8-bit/4-bit-error instance run from shared stimulus.
module tb_position_tracker_quad;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int   a_in, b_in, lo, up;
  logic s_valid, m_ready, mode, clear;
  logic signed [15:0] thr_lo, thr_up;
  logic [31:0] tdata;
  logic [15:0] err_w;
  logic [3:0]  err_n;

  assign thr_lo = lo[15:0];
  assign thr_up = up[15:0];
  assign tdata  = {b_in[15:0], a_in[15:0]};

  position_tracker_quad_if #(.AXIS_TDATA_WIDTH(32), .POSITION_WIDTH(32)) bus_w ();
  position_tracker_quad_if #(.AXIS_TDATA_WIDTH(32), .POSITION_WIDTH(8))  bus_n ();

  assign bus_w.S_AXIS_tvalid = s_valid;
  assign bus_w.S_AXIS_tdata  = tdata;
  assign bus_w.M_AXIS_tready = m_ready;
  assign bus_n.S_AXIS_tvalid = s_valid;
  assign bus_n.S_AXIS_tdata  = tdata;
  assign bus_n.M_AXIS_tready = m_ready;

  position_tracker_quad #(.AXIS_TDATA_WIDTH(32), .POSITION_WIDTH(32), .ERR_WIDTH(16)) dut_w (
    .SYS_aclk(clk), .SYS_aresetn(rst_n),
    .FC_lower_threshold(thr_lo), .FC_upper_threshold(thr_up),
    .FC_mode(mode), .FC_clear(clear),
    .axis(bus_w), .ST_error_count(err_w)
  );

  position_tracker_quad #(.AXIS_TDATA_WIDTH(32), .POSITION_WIDTH(8), .ERR_WIDTH(4)) dut_n (
    .SYS_aclk(clk), .SYS_aresetn(rst_n),
    .FC_lower_threshold(thr_lo), .FC_upper_threshold(thr_up),
    .FC_mode(mode), .FC_clear(clear),
    .axis(bus_n), .ST_error_count(err_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: channel level 0=unknown, 1=low, 2=high; position per instance width.
  int          ma, mb;
  logic [31:0] mpos_w;
  logic [7:0]  mpos_n;
  int          merr_w, merr_n;
  logic        mtv_w, mtv_n;
  int          cur_ph;

  function automatic int slice(input int s, input int x);
    if (x < lo && (s == 0 || s == 2)) return 1;
    if (x > up && (s == 0 || s == 1)) return 2;
    return s;
  endfunction

  // Quadrature phase around the cycle 00 -> 10 -> 11 -> 01, with (A,B) high = 1.
  function automatic int phase(input int sa, input int sb);
    if (sa == 2) return (sb == 2) ? 2 : 1;
    return (sb == 2) ? 3 : 0;
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0;
    mpos_w = '0; mpos_n = '0;
    merr_w = 0; merr_n = 0;
    mtv_w = 1'b0; mtv_n = 1'b0;
  endtask

  task automatic model_step();
    int na, nb, d, df;
    bit e;
    logic [31:0] nw;
    logic [7:0]  nn;
    na = ma; nb = mb; d = 0; e = 1'b0;
    if (s_valid) begin
      if (lo <= up) begin
        na = slice(ma, a_in);
        nb = slice(mb, b_in);
      end
      if (ma != 0 && mb != 0) begin
        if (!mode) begin
          if (ma == 2 && na == 1) d = (mb == 2) ? 1 : -1;
        end else begin
          df = (phase(na, nb) - phase(ma, mb) + 4) % 4;
          if (df == 1) d = 1;
          else if (df == 3) d = -1;
          else if (df == 2) e = 1'b1;
        end
      end
    end
    nw = clear ? 32'd0 : mpos_w + d;
    nn = clear ? 8'd0  : 8'(mpos_n + d);
    mtv_w = (nw != mpos_w) ? 1'b1 : (m_ready ? 1'b0 : mtv_w);
    mtv_n = (nn != mpos_n) ? 1'b1 : (m_ready ? 1'b0 : mtv_n);
    mpos_w = nw;
    mpos_n = nn;
    merr_w = clear ? 0 : ((e && merr_w < 65535) ? merr_w + 1 : merr_w);
    merr_n = clear ? 0 : ((e && merr_n < 15) ? merr_n + 1 : merr_n);
    ma = na; mb = nb;
  endtask

  task automatic check_all();
    check_eq("tdata_w",  64'(bus_w.M_AXIS_tdata),  64'(mpos_w));
    check_eq("tvalid_w", 64'(bus_w.M_AXIS_tvalid), 64'(mtv_w));
    check_eq("err_w",    64'(err_w),               64'(merr_w));
    check_eq("tdata_n",  64'(bus_n.M_AXIS_tdata),  64'(mpos_n));
    check_eq("tvalid_n", 64'(bus_n.M_AXIS_tvalid), 64'(mtv_n));
    check_eq("err_n",    64'(err_n),               64'(merr_n));
    check_eq("tready",   64'({bus_w.S_AXIS_tready, bus_n.S_AXIS_tready}), 64'd3);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all();
  endtask

  task automatic sample(input int a, input int b);
    s_valid = 1'b1; a_in = a; b_in = b;
    tick();
  endtask

  task automatic clear_tick();
    s_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic x4_step(input int dir, input logic with_clear);
    cur_ph = (cur_ph + dir + 4) % 4;
    clear = with_clear;
    case (cur_ph)
      0: sample(-500, -500);
      1: sample( 500, -500);
      2: sample( 500,  500);
      default: sample(-500, 500);
    endcase
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; mode = 1'b0; clear = 1'b0;
    a_in = 0; b_in = 0; lo = -100; up = 100; cur_ph = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // x1 count-up with B high
    sample(500, 500);
    for (int i = 0; i < 3; i++) begin
      sample(-500, 500);
      sample(500, 500);
    end
    check_eq("x1_up", 64'(bus_w.M_AXIS_tdata), 64'd3);

    // x1 count-down with B low
    clear_tick();
    sample(500, -500);
    sample(-500, -500);
    check_eq("x1_dn1", 64'(bus_w.M_AXIS_tdata), 64'hFFFF_FFFF);
    sample(500, -500);
    sample(-500, -500);
    check_eq("x1_dn2", 64'(bus_w.M_AXIS_tdata), 64'hFFFF_FFFE);

    // x4 forward then reverse; channels sit at (L,L)
    mode = 1'b1; cur_ph = 0;
    clear_tick();
    for (int i = 0; i < 4; i++) x4_step(1, 1'b0);
    check_eq("x4_fwd", 64'(bus_w.M_AXIS_tdata), 64'd4);
    for (int i = 0; i < 4; i++) x4_step(-1, 1'b0);
    check_eq("x4_rev", 64'(bus_w.M_AXIS_tdata), 64'd0);

    // illegal double transitions and error saturation
    clear_tick();
    x4_step(2, 1'b0);
    check_eq("ill_pos", 64'(bus_w.M_AXIS_tdata), 64'd0);
    check_eq("ill_err", 64'(err_w), 64'd1);
    for (int i = 1; i < 20; i++) x4_step(2, 1'b0);
    check_eq("err_sat", 64'(err_n), 64'd15);
    check_eq("err_20",  64'(err_w), 64'd20);

    // 8-bit wrap and clear priority
    clear_tick();
    for (int i = 0; i < 127; i++) x4_step(1, 1'b0);
    check_eq("pos127", 64'(bus_n.M_AXIS_tdata), 64'd127);
    x4_step(1, 1'b1);
    check_eq("clr_win", 64'(bus_n.M_AXIS_tdata), 64'd0);
    for (int i = 0; i < 128; i++) x4_step(1, 1'b0);
    check_eq("wrap", 64'(bus_n.M_AXIS_tdata), 64'h80);

    // back-pressure: latest value wins
    clear_tick();
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) x4_step(1, 1'b0);
    check_eq("bp_data", 64'(bus_w.M_AXIS_tdata), 64'd3);
    check_eq("bp_vld",  64'(bus_w.M_AXIS_tvalid), 64'd1);
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    check_eq("bp_drop", 64'(bus_w.M_AXIS_tvalid), 64'd0);

    // async reset discards a pending output; slicers must re-qualify afterwards
    m_ready = 1'b0;
    x4_step(1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    x4_step(1, 1'b0);
    x4_step(1, 1'b0);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      a_in    = int'($urandom_range(0, 1200)) - 600;
      b_in    = int'($urandom_range(0, 1200)) - 600;
      m_ready = ($urandom_range(0, 9) < 7);
      clear   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      case ($urandom_range(0, 79))
        0: begin lo = 100;  up = -100; end
        1: begin lo = -100; up = 100;  end
        2: begin lo = -20;  up = 250;  end
        default: ;
      endcase
      tick();
    end
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/position_tracker_quad.md
POSITION_TRACKER_QUAD -- requirements
Module: position_tracker_quad

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning input word width, even; low half is signal A, high half is signal B, both signed.
REQ-002 SHALL have parameter POSITION_WIDTH, default 32, meaning signed position counter and M_AXIS_tdata width, range 8..64.
REQ-003 SHALL have parameter ERR_WIDTH, default 16, meaning error counter width.
REQ-004 SHALL have port SYS_aclk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port SYS_aresetn, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port FC_lower_threshold, input, AXIS_TDATA_WIDTH/2, signed lower hysteresis threshold shared by A and B.
REQ-007 SHALL have port FC_upper_threshold, input, AXIS_TDATA_WIDTH/2, signed upper hysteresis threshold shared by A and B.
REQ-008 SHALL have port FC_mode, input, 1; 0 = x1 decode, 1 = x4 decode.
REQ-009 SHALL have port FC_clear, input, 1, synchronous clear of position and error counter.
REQ-010 SHALL have ports S_AXIS_tvalid (input, 1), S_AXIS_tdata (input, AXIS_TDATA_WIDTH) and S_AXIS_tready (output, 1), the sample stream.
REQ-011 SHALL have ports M_AXIS_tready (input, 1), M_AXIS_tvalid (output, 1) and M_AXIS_tdata (output, POSITION_WIDTH), the position stream.
REQ-012 SHALL have port ST_error_count, output, ERR_WIDTH, count of illegal quadrature transitions.

Function
REQ-013 SHALL drive S_AXIS_tready constant 1; a sample is accepted only in a cycle with S_AXIS_tvalid=1; with tvalid=0 no channel state, position or error count changes.
REQ-014 SHALL run one hysteresis FSM per channel, states IDLE, LOW, HIGH: IDLE->LOW if x<lower; IDLE->HIGH if x>upper; LOW->HIGH if x>upper; HIGH->LOW if x<lower; otherwise hold; all compares signed and strict.
REQ-015 SHALL hold both FSMs in their current state whenever signed lower > signed upper.
REQ-016 SHALL generate no count or error event while either FSM is IDLE, including the cycle in which it leaves IDLE.
REQ-017 In x1 mode, on an A HIGH->LOW transition, SHALL apply +1 if B's pre-update state is HIGH and -1 if it is LOW; B transitions in the same cycle use the pre-update B state.
REQ-018 In x4 mode, with (A,B) encoded as HIGH=1: 00->10, 10->11, 11->01, 01->00 SHALL apply +1; the reverse transitions SHALL apply -1; no change SHALL apply 0.
REQ-019 In x4 mode, a simultaneous change of A and B (00<->11, 10<->01) SHALL leave position unchanged and increment the error counter.
REQ-020 Position SHALL wrap modulo 2^POSITION_WIDTH (two's complement) with no saturation.
REQ-021 The error counter SHALL saturate at all-ones.
REQ-022 FC_mode changes SHALL take effect on the next accepted sample without altering position or the FSMs.
REQ-023 FC_clear=1 SHALL set position and error count to 0 at the next edge and SHALL override any same-cycle count or error event; the FSMs are not cleared.
REQ-024 Latency SHALL be one cycle: a sample accepted at edge n SHALL have its position result visible on M_AXIS_tdata after edge n.
REQ-025 M_AXIS_tdata SHALL always equal the registered position.
REQ-026 M_AXIS_tvalid SHALL set on any edge where position changes (including by clear) and clear on an edge where M_AXIS_tready=1 and no new change occurs.
REQ-027 While M_AXIS_tvalid is high and not yet accepted, further changes SHALL update tdata in place and keep tvalid high; intermediate values are not buffered, so the latest position wins.

Reset
REQ-028 While SYS_aresetn=0 the block SHALL immediately hold: position 0, both FSMs IDLE, M_AXIS_tvalid 0, ST_error_count 0, S_AXIS_tready 1.
REQ-029 Reset asserted mid-operation SHALL discard any pending unaccepted output; after deassertion, the first count requires both channels to leave IDLE again.

Verification
REQ-030 With lower=-100, upper=100, x1 mode, B held at +500, and A cycling +500/-500 for 3 periods, the bench SHALL see position step 1, 2, 3 with one tvalid pulse per step when tready=1.
REQ-031 With B held at -500 in the scenario of REQ-030 and A cycling for 2 periods, the bench SHALL see position 0xFFFFFFFF then 0xFFFFFFFE.
REQ-032 In x4 mode with (A,B) driven 00,10,11,01,00 and then reversed, the bench SHALL see position 1,2,3,4 then 3,2,1,0.
REQ-033 In x4 mode, driving (A,B) 00->11 SHALL leave position unchanged and set ST_error_count to 1; with ERR_WIDTH=4, 20 such events SHALL leave ST_error_count at 15.
REQ-034 With POSITION_WIDTH=8, position 127, a +1 event and FC_clear in the same cycle SHALL give position 0; without FC_clear, a +1 event from 127 SHALL give -128.
REQ-035 With M_AXIS_tready=0 and 3 count events, then tready=1, the bench SHALL see tvalid high throughout, tdata=3 at acceptance, and tvalid low the following cycle.
